// File: rtl/reg_share_arbiter_if.sv
// Bundle of per-requester request/write/release signals and the shared-register
// status returned by reg_share_arbiter.
interface reg_share_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]       req;
    logic [N-1:0]       wr_en;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       last;
    logic [N-1:0]       gnt;
    logic [WIDTH-1:0]   q;
    logic               busy;
    logic [IDW-1:0]     owner_id;
    logic               timeout;

    modport master (
        output req, wr_en, wdata, last,
        input  gnt, q, busy, owner_id, timeout
    );

    modport slave (
        input  req, wr_en, wdata, last,
        output gnt, q, busy, owner_id, timeout
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin owner arbitration for one shared WIDTH-bit register: only the
// current owner may write it, and ownership ends on last, withdrawal or timeout.
module reg_share_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_share_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(MAX_HOLD);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [N-1:0]     r_gnt;
    logic [WIDTH-1:0] r_q;
    logic [IDW-1:0]   r_ownerId;
    logic [IDW-1:0]   r_ptr;
    logic [CW-1:0]    r_holdCnt;
    logic             r_timeout;

    logic [N-1:0]     w_rotReq;
    logic             w_found;
    logic [IDW:0]     w_offset;
    logic [IDW:0]     w_rawSum;
    logic [IDW-1:0]   w_sel;
    logic             w_expired;
    logic             w_ownerWrite;
    logic             w_release;
    logic             w_forced;
    logic [IDW-1:0]   w_ptrNext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_found)   w_nextState = OWNED;
            OWNED:   if (w_release) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Rotate requests so bit 0 is the pointer's position; the lowest set bit
    // then gives the round-robin winner as an offset from the pointer.
    always_comb begin
        w_rotReq = N'({bus.req, bus.req} >> r_ptr);
        w_found  = 1'b0;
        w_offset = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rotReq[k]) begin
                w_found  = 1'b1;
                w_offset = (IDW+1)'(k);
            end
        end
        w_rawSum = {1'b0, r_ptr} + w_offset;
        if (w_rawSum >= (IDW+1)'(N)) begin
            w_sel = IDW'(w_rawSum - (IDW+1)'(N));
        end else begin
            w_sel = w_rawSum[IDW-1:0];
        end

        w_expired    = (r_holdCnt == CW'(MAX_HOLD - 1));
        w_ownerWrite = (r_state == OWNED) && bus.wr_en[r_ownerId];
        w_release    = (r_state == OWNED) &&
                       (bus.last[r_ownerId] || !bus.req[r_ownerId] || w_expired);
        w_forced     = (r_state == OWNED) && w_expired &&
                       bus.req[r_ownerId] && !bus.last[r_ownerId];
        w_ptrNext    = (r_ownerId == IDW'(N - 1)) ? '0 : r_ownerId + IDW'(1);
    end

    // A write from the owner lands even on its releasing edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt     <= '0;
            r_q       <= '0;
            r_ownerId <= '0;
            r_ptr     <= '0;
            r_holdCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_ownerWrite) begin
                r_q <= bus.wdata[r_ownerId*WIDTH +: WIDTH];
            end
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt     <= N'(1) << w_sel;
                        r_ownerId <= w_sel;
                        r_holdCnt <= '0;
                    end
                end
                OWNED: begin
                    if (w_release) begin
                        r_gnt     <= '0;
                        r_ptr     <= w_ptrNext;
                        r_timeout <= w_forced;
                    end else begin
                        r_holdCnt <= r_holdCnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.q        = r_q;
    assign bus.busy     = |r_gnt;
    assign bus.owner_id = r_ownerId;
    assign bus.timeout  = r_timeout;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: an ownership-level model checked every
// cycle, plus hand-computed expectations at each step of the directed sequence.
module tb_reg_share_arbiter;
    localparam int N        = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 8;
    localparam int IDW      = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   checkEn = 1'b0;
    int   nCompared   = 0;
    int   nMismatched = 0;

    reg_share_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus();

    reg_share_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: who owns the register (-1 = nobody), for how many cycles the
    // grant has been visible, and where the next search begins.
    int               mOwner     = -1;
    int               mPtr       = 0;
    int               mHeld      = 0;
    int               mLastOwner = 0;
    logic [WIDTH-1:0] mQ         = '0;
    bit               mTimeout   = 1'b0;

    always @(posedge clk or negedge reset) begin
        int  c;
        int  o;
        bit  rel;
        if (!reset) begin
            mOwner = -1; mPtr = 0; mHeld = 0; mLastOwner = 0; mQ = '0; mTimeout = 1'b0;
        end else if (mOwner < 0) begin
            mTimeout = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (mPtr + k) % N;
                if (mOwner < 0 && bus.req[c]) begin
                    mOwner = c; mHeld = 1; mLastOwner = c;
                end
            end
        end else begin
            o = mOwner;
            if (bus.wr_en[o]) mQ = bus.wdata[o*WIDTH +: WIDTH];
            rel      = bus.last[o] || !bus.req[o] || (mHeld == MAX_HOLD);
            mTimeout = rel && bus.req[o] && !bus.last[o] && (mHeld == MAX_HOLD);
            if (rel) begin
                mOwner = -1;
                mPtr   = (o + 1) % N;
            end else begin
                mHeld++;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (checkEn) begin
            eg = (mOwner < 0) ? '0 : (N'(1) << mOwner);
            cmp("cycle.gnt",      32'(bus.gnt),      32'(eg));
            cmp("cycle.q",        32'(bus.q),        32'(mQ));
            cmp("cycle.busy",     32'(bus.busy),     32'(mOwner >= 0));
            cmp("cycle.owner_id", 32'(bus.owner_id), 32'(mLastOwner));
            cmp("cycle.timeout",  32'(bus.timeout),  32'(mTimeout));
        end
    end

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] w,
                                 input logic [N*WIDTH-1:0] d, input logic [N-1:0] l);
        bus.req   = r;
        bus.wr_en = w;
        bus.wdata = d;
        bus.last  = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] eg, input logic [WIDTH-1:0] eq,
                               input logic eb, input logic [IDW-1:0] eo, input logic et);
        cmp({tag, ".gnt"},      32'(bus.gnt),      32'(eg));
        cmp({tag, ".q"},        32'(bus.q),        32'(eq));
        cmp({tag, ".busy"},     32'(bus.busy),     32'(eb));
        cmp({tag, ".owner_id"}, 32'(bus.owner_id), 32'(eo));
        cmp({tag, ".timeout"},  32'(bus.timeout),  32'(et));
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        applyStimulus('0, '0, '0, '0);
        #1 reset = 1'b0;
        applyStimulus(N'($urandom), N'($urandom), 32'($urandom), N'($urandom));
        #2;
        checkOutput("reset", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
        checkEn = 1'b1;
        tick();
        applyStimulus(N'($urandom), N'($urandom), 32'($urandom), N'($urandom));
        tick();
        checkOutput("reset_hold", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
        applyStimulus('0, '0, '0, '0);
        reset = 1'b1;
        tick();
        checkOutput("reset_release", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, '0, '0, '0);
            tick();
            checkOutput($sformatf("rr_grant%0d", i), N'(1) << order[i], 8'h00, 1'b1, IDW'(order[i]), 1'b0);
            applyStimulus(4'b1111, '0, '0, N'(1) << order[i]);
            tick();
            checkOutput($sformatf("rr_bubble%0d", i), 4'b0000, 8'h00, 1'b0, IDW'(order[i]), 1'b0);
        end
        applyStimulus('0, '0, '0, '0);
        tick();

        applyStimulus(4'b0100, '0, '0, '0);
        tick();
        checkOutput("single_grant", 4'b0100, 8'h00, 1'b1, 2'd2, 1'b0);
        applyStimulus(4'b0100, 4'b0100, 32'h00A5_0000, '0);
        tick();
        checkOutput("single_write", 4'b0100, 8'hA5, 1'b1, 2'd2, 1'b0);
        applyStimulus(4'b0100, '0, '0, 4'b0100);
        tick();
        checkOutput("single_last", 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b0);
        applyStimulus('0, '0, '0, '0);
        tick();
        checkOutput("single_idle", 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b0);

        applyStimulus(4'b0010, '0, '0, '0);
        tick();
        checkOutput("nonown_grant", 4'b0010, 8'hA5, 1'b1, 2'd1, 1'b0);
        applyStimulus(4'b0010, 4'b0010, 32'h0000_1100, '0);
        tick();
        checkOutput("nonown_ownwrite", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b0);
        applyStimulus(4'b0010, 4'b1000, 32'hFF00_0000, 4'b1000);
        tick();
        checkOutput("nonown_ignored", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b0);
        applyStimulus('0, '0, '0, '0);
        tick();
        checkOutput("withdraw", 4'b0000, 8'h11, 1'b0, 2'd1, 1'b0);

        applyStimulus(4'b0011, '0, '0, '0);
        tick();
        checkOutput("to_grant", 4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            tick();
            checkOutput($sformatf("to_hold%0d", i), 4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);
        end
        tick();
        checkOutput("to_expire", 4'b0000, 8'h11, 1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("to_next", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b0);
        applyStimulus('0, '0, '0, '0);
        tick();
        checkOutput("to_done", 4'b0000, 8'h11, 1'b0, 2'd1, 1'b0);

        applyStimulus(4'b0001, '0, '0, '0);
        tick();
        checkOutput("tolast_grant", 4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        applyStimulus(4'b0001, '0, '0, 4'b0001);
        tick();
        checkOutput("tolast_release", 4'b0000, 8'h11, 1'b0, 2'd0, 1'b0);
        applyStimulus('0, '0, '0, '0);
        tick();
        checkOutput("tolast_after", 4'b0000, 8'h11, 1'b0, 2'd0, 1'b0);

        applyStimulus(4'b0100, '0, '0, '0);
        tick();
        checkOutput("async_grant", 4'b0100, 8'h11, 1'b1, 2'd2, 1'b0);
        applyStimulus(4'b0100, 4'b0100, 32'h003C_0000, '0);
        tick();
        checkOutput("async_write", 4'b0100, 8'h3C, 1'b1, 2'd2, 1'b0);
        applyStimulus(4'b0100, '0, '0, '0);
        #1 reset = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        applyStimulus(4'b1100, '0, '0, '0);
        tick();
        checkOutput("async_regrant", 4'b0100, 8'h00, 1'b1, 2'd2, 1'b0);
        applyStimulus('0, '0, '0, '0);
        tick();
        tick();

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
